// File: rtl/mips_trace_pkg.sv
// Shared types and constants for the writeback trace capture block.
// Optional macro MIPS_WB_TRACE_PC_EN adds the writeback PC to every entry.
package mips_trace_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned PC_W   = 32;

  localparam logic [PC_W-1:0] END_PC_DEFAULT = 32'h58;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } trace_state_e;

  typedef struct packed {
`ifdef MIPS_WB_TRACE_PC_EN
    logic [PC_W-1:0]   pc;
`endif
    logic [REG_W-1:0]  reg_num;
    logic [DATA_W-1:0] data;
  } trace_entry_t;

  localparam int unsigned ENTRY_W = $bits(trace_entry_t);

endpackage

// File: rtl/mips_wb_trace_if.sv
// Trace drain port: valid/ready handshake plus the head entry payload.
// Optional macro MIPS_WB_TRACE_PC_EN adds tr_pc.
interface mips_wb_trace_if;
  import mips_trace_pkg::*;

  logic              tr_valid;
  logic              tr_ready;
  logic [REG_W-1:0]  tr_reg;
  logic [DATA_W-1:0] tr_data;
`ifdef MIPS_WB_TRACE_PC_EN
  logic [PC_W-1:0]   tr_pc;
`endif

  modport master (
    output tr_valid,
    output tr_reg,
    output tr_data,
`ifdef MIPS_WB_TRACE_PC_EN
    output tr_pc,
`endif
    input  tr_ready
  );

  modport slave (
    input  tr_valid,
    input  tr_reg,
    input  tr_data,
`ifdef MIPS_WB_TRACE_PC_EN
    input  tr_pc,
`endif
    output tr_ready
  );

endinterface

// File: rtl/mips_trace_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers and a registered-storage head.
module mips_trace_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push_c;
  logic             do_pop_c;

  // Full/empty from the wrap bit; a push into a full FIFO succeeds when a pop frees a slot.
  always_comb begin
    empty_o   = (wr_ptr_q == rd_ptr_q);
    full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop_c  = pop_i & ~empty_o;
    do_push_c = push_i & (~full_o | do_pop_c);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (do_push_c) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop_c)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    count_o   = wr_ptr_q - rd_ptr_q;
    head_o    = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (do_push_c) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/mips_wb_trace.sv
// Captures register writebacks into a trace FIFO until END_PC is fetched,
// then drains and raises done. Optional macro MIPS_WB_TRACE_PC_EN adds
// wb_pc capture and the tr_pc output.
module mips_wb_trace
  import mips_trace_pkg::*;
#(
  parameter int unsigned      DEPTH  = 16,
  parameter logic [PC_W-1:0]  END_PC = END_PC_DEFAULT,
  parameter int unsigned      CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PC_W-1:0]   pc,
  input  logic              wb_we,
  input  logic [REG_W-1:0]  wb_reg,
  input  logic [DATA_W-1:0] wb_data,
`ifdef MIPS_WB_TRACE_PC_EN
  input  logic [PC_W-1:0]   wb_pc,
`endif
  mips_wb_trace_if.master   tr,
  output logic [CNT_W-1:0]  tr_count,
  output logic              overflow,
  output logic              done
);

  localparam int unsigned AW = $clog2(DEPTH);

  trace_state_e   state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic           overflow_q, overflow_d;

  logic           fifo_full;
  logic           fifo_empty;
  logic [AW:0]    fifo_count;
  trace_entry_t   fifo_head;
  trace_entry_t   push_entry_c;

  logic           event_c;
  logic           pop_c;
  logic           push_c;
  logic           drop_c;

  // Entry assembled from the writeback stage.
  always_comb begin
    push_entry_c         = '0;
    push_entry_c.reg_num = wb_reg;
    push_entry_c.data    = wb_data;
`ifdef MIPS_WB_TRACE_PC_EN
    push_entry_c.pc      = wb_pc;
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Next state plus event qualification; DRAIN exits once the FIFO is empty after this edge's pop.
  always_comb begin
    state_d = state_q;
    event_c = 1'b0;
    pop_c   = ~fifo_empty & tr.tr_ready;
    push_c  = 1'b0;
    drop_c  = 1'b0;
    case (state_q)
      RUN: begin
        event_c = wb_we && (wb_reg != '0);
        push_c  = event_c & (~fifo_full | pop_c);
        drop_c  = event_c & fifo_full & ~pop_c;
        if (pc == END_PC) state_d = DRAIN;
      end
      DRAIN: begin
        if (fifo_empty || (pop_c && fifo_count == (AW+1)'(1))) state_d = DONE;
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Saturating accept counter and sticky overflow.
  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_c && count_q != '1) count_d = count_q + CNT_W'(1);
    if (drop_c)                  overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  mips_trace_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .data_i  (push_entry_c),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head),
    .count_o (fifo_count)
  );

  // Head presented from storage; forced to zero while empty so reset shows all zeros.
  always_comb begin
    tr.tr_valid = ~fifo_empty;
    tr.tr_reg   = fifo_empty ? '0 : fifo_head.reg_num;
    tr.tr_data  = fifo_empty ? '0 : fifo_head.data;
`ifdef MIPS_WB_TRACE_PC_EN
    tr.tr_pc    = fifo_empty ? '0 : fifo_head.pc;
`endif
    tr_count    = count_q;
    overflow    = overflow_q;
    done        = (state_q == DONE);
  end

endmodule

// File: tb/tb_mips_wb_trace.sv
// Directed bench for mips_wb_trace with a scoreboard queue and a negedge monitor.
module tb_mips_wb_trace;
  import mips_trace_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        wb_we;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
`ifdef MIPS_WB_TRACE_PC_EN
  logic [31:0] wb_pc;
`endif
  logic        ready;
  logic [15:0] tr_count;
  logic        overflow;
  logic        done;

  mips_wb_trace_if tr();
  assign tr.tr_ready = ready;

  mips_wb_trace #(
    .DEPTH  (16),
    .END_PC (32'h58),
    .CNT_W  (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pc       (pc),
    .wb_we    (wb_we),
    .wb_reg   (wb_reg),
    .wb_data  (wb_data),
`ifdef MIPS_WB_TRACE_PC_EN
    .wb_pc    (wb_pc),
`endif
    .tr       (tr),
    .tr_count (tr_count),
    .overflow (overflow),
    .done     (done)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_pops   = 0;
  logic [36:0] sb [$];
  logic        stall;
  logic [36:0] held;
  logic [36:0] exp_e;
  int          it;
  int          pops0;
  logic        seen_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] r, input logic [31:0] d,
                       input logic rdy, input logic [31:0] p, input logic exp_push);
    wb_we   = we;
    wb_reg  = r;
    wb_data = d;
    ready   = rdy;
    pc      = p;
    if (exp_push) sb.push_back({r, d});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 5'd0, 32'd0, rdy, 32'd0, 1'b0);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #3;
    reset = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset   = 1'b0;
    pc      = '0;
    wb_we   = 1'b0;
    wb_reg  = '0;
    wb_data = '0;
    ready   = 1'b0;
    stall   = 1'b0;
    held    = '0;
`ifdef MIPS_WB_TRACE_PC_EN
    wb_pc   = 32'h100;
`endif
    fork
      // Monitor: compares every handshake against the scoreboard and checks stall stability.
      begin
        forever begin
          @(negedge clk);
          if (!reset) begin
            stall = 1'b0;
          end else begin
            if (stall) begin
              chk("hold_valid", 64'(tr.tr_valid), 64'd1);
              chk("hold_entry", 64'({tr.tr_reg, tr.tr_data}), 64'(held));
            end
            if (tr.tr_valid && tr.tr_ready) begin
              n_pops++;
              if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_entry: got %0h expected none", {tr.tr_reg, tr.tr_data});
              end else begin
                exp_e = sb.pop_front();
                chk("entry", 64'({tr.tr_reg, tr.tr_data}), 64'(exp_e));
              end
            end
            stall = tr.tr_valid && !tr.tr_ready;
            held  = {tr.tr_reg, tr.tr_data};
          end
        end
      end
      // Stimulus.
      begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(tr.tr_valid), 64'd0);
        chk("rst_reg", 64'(tr.tr_reg), 64'd0);
        chk("rst_data", 64'(tr.tr_data), 64'd0);
        chk("rst_count", 64'(tr_count), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        reset = 1'b1;

        // Writes to $0 are ignored.
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 32'd0, 1'b0);
        idle(1'b1);
        chk("zero_valid", 64'(tr.tr_valid), 64'd0);
        chk("zero_count", 64'(tr_count), 64'd0);

        // Single event, one-cycle latency.
        drive(1'b1, 5'd8, 32'h5, 1'b1, 32'd0, 1'b1);
        chk("single_valid", 64'(tr.tr_valid), 64'd1);
        chk("single_reg", 64'(tr.tr_reg), 64'd8);
        idle(1'b1);
        chk("single_count", 64'(tr_count), 64'd1);
        chk("single_drained", 64'(tr.tr_valid), 64'd0);

        // Fill to 16, drop the 17th, then full-with-pop accepts.
        apply_reset();
        for (int i = 1; i <= 17; i++)
          drive(1'b1, 5'(i), 32'(i), 1'b0, 32'd0, (i <= 16));
        idle(1'b0);
        chk("full_overflow", 64'(overflow), 64'd1);
        chk("full_count", 64'(tr_count), 64'd16);
        drive(1'b1, 5'd18, 32'd18, 1'b1, 32'd0, 1'b1);
        repeat (18) idle(1'b1);
        chk("full_pop_count", 64'(tr_count), 64'd17);
        chk("full_overflow_sticky", 64'(overflow), 64'd1);
        chk("full_drained", 64'(tr.tr_valid), 64'd0);

        // Back-pressure burst with toggling ready.
        for (int i = 0; i < 5; i++)
          drive(1'b1, 5'(20 + i), 32'h100 + 32'(i), (i % 2 == 0), 32'd0, 1'b1);
        for (int i = 0; i < 10; i++) idle(i % 2 == 0);
        chk("bp_count", 64'(tr_count), 64'd22);
        chk("bp_drained", 64'(tr.tr_valid), 64'd0);

        // Asynchronous reset mid-cycle with 5 held entries.
        for (int i = 1; i <= 5; i++)
          drive(1'b1, 5'(i), 32'hA0 + 32'(i), 1'b0, 32'd0, 1'b1);
        idle(1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", 64'(tr.tr_valid), 64'd0);
        chk("arst_reg", 64'(tr.tr_reg), 64'd0);
        chk("arst_data", 64'(tr.tr_data), 64'd0);
        chk("arst_count", 64'(tr_count), 64'd0);
        chk("arst_overflow", 64'(overflow), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(1'b1, 5'd3, 32'hABC, 1'b1, 32'd0, 1'b1);
        repeat (2) idle(1'b1);
        chk("arst_recount", 64'(tr_count), 64'd1);

        // End of program: END_PC with a 4th event, later event ignored, then drain.
        apply_reset();
        for (int i = 1; i <= 3; i++)
          drive(1'b1, 5'(i), 32'h30 + 32'(i), 1'b0, 32'd0, 1'b1);
        drive(1'b1, 5'd4, 32'h34, 1'b0, 32'h58, 1'b1);
        drive(1'b1, 5'd9, 32'h99, 1'b0, 32'd0, 1'b0);
        idle(1'b0);
        chk("end_done_early", 64'(done), 64'd0);
        chk("end_count", 64'(tr_count), 64'd4);
        pops0     = n_pops;
        seen_done = 1'b0;
        it        = 0;
        while (!seen_done && it < 20) begin
          idle(1'b1);
          it++;
          @(negedge clk);
          #1;
          if (done) seen_done = 1'b1;
        end
        chk("end_done_seen", 64'(seen_done), 64'd1);
        chk("end_done_cycle", 64'(it), 64'd4);
        chk("end_pops", 64'(n_pops - pops0), 64'd4);
        chk("end_valid", 64'(tr.tr_valid), 64'd0);
        drive(1'b1, 5'd9, 32'h99, 1'b1, 32'h58, 1'b0);
        idle(1'b1);
        chk("end_done_hold", 64'(done), 64'd1);
        chk("end_count_final", 64'(tr_count), 64'd4);
        chk("sb_empty", 64'(sb.size()), 64'd0);
      end
      // Watchdog.
      begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
      end
    join_any
    disable fork;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_wb_trace.md
Name: mips_wb_trace

Overview:
- Hardware capture of the pipeline's register-writeback stream into an on-chip trace FIFO, drained by a consumer over a valid/ready port.
- Sits beside the pipelined CPU top. It consumes the writeback debug signals (write enable, destination register, write data) and the fetch PC, and stops capturing once the program's end PC is fetched.
- It replaces bench-side printing with a bounded, checkable trace and a done flag.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2.
- END_PC, 32'h58, fetch PC that ends capture.
- CNT_W, 16, width of the accepted-event counter.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- pc  in  32  current fetch PC
- wb_we  in  1  writeback-stage register write enable
- wb_reg  in  5  writeback-stage destination register
- wb_data  in  32  writeback-stage write data
- tr_valid  out  1  trace entry available
- tr_ready  in  1  consumer accepts entry
- tr_reg  out  5  entry register number
- tr_data  out  32  entry write data
- tr_count  out  CNT_W  events accepted into FIFO; saturating
- overflow  out  1  sticky: an event was dropped
- done  out  1  END_PC reached and FIFO drained

Behaviour:
- Reset (reset=0, asynchronous) sets state RUN, FIFO empty, and all outputs 0: tr_valid, tr_reg, tr_data, tr_count, overflow, done.
- Event definition: a cycle with wb_we=1 and wb_reg!=0 while state=RUN. Writes to $0 are never events.
- Push timing: an event pushes {wb_reg, wb_data} at that clock edge. With the FIFO empty, tr_valid rises the following cycle (1-cycle latency).
- Head output: tr_reg and tr_data show the FIFO head combinationally from registered storage. They are stable while tr_valid=1 and tr_ready=0.
- Pop: occurs when tr_valid & tr_ready at a clock edge.
- Full, no pop: the event is dropped, overflow is set and stays set until reset, and tr_count is unchanged.
- Full with a same-cycle pop: the push is accepted and nothing is dropped.
- Empty with a same-cycle event: no pop, because tr_valid is 0.
- Pointers: log2(DEPTH) bits plus one wrap bit. full and empty are derived from the wrap bit.
- tr_count increments per accepted push and saturates at all-ones.
- States:
  - RUN: capture enabled. Goes to DRAIN when pc==END_PC. An event in that same cycle is still captured.
  - DRAIN: no capture. Pops continue. Goes to DONE when the FIFO is empty, evaluated after the current edge's pop.
  - DONE: done=1. No capture. Held until reset.
- If pc==END_PC and the FIFO is empty in the same cycle: RUN goes to DRAIN, then to DONE on the next edge, so done asserts 2 cycles after the END_PC cycle.
- Reset mid-operation: all FIFO contents are discarded and state returns to RUN with no residual tr_valid.
- pc is compared only in RUN. Later fetches of END_PC have no effect.

Optional Feature:
- Macro: MIPS_WB_TRACE_PC_EN
- Defined:
  - Adds input wb_pc (32, PC of the writeback-stage instruction) and output tr_pc (32).
  - Each entry stores wb_pc alongside reg and data, so the FIFO width grows to 69 bits.
  - tr_pc follows the same head and stability rules as tr_data and resets to 0.
- Undefined: neither port exists and the entry is 37 bits. All other behaviour is identical.

Decomposition:
- Package mips_trace_pkg holds:
  - the state enum (RUN, DRAIN, DONE)
  - the default END_PC constant
  - the entry struct type (reg, data, and pc under the macro)
  - the register-width constant 5
- Sub-module mips_trace_fifo: a generic synchronous FIFO (WIDTH, DEPTH), reset the same way, with push, pop, full, empty and head. The top handles the state machine, event qualification, counter and overflow.

Test Plan:
- Single event: wb_we=1, wb_reg=8, wb_data=32'h5 for one cycle, tr_ready=1 → next cycle tr_valid=1, tr_reg=8, tr_data=5; popped; tr_count=1.
- $0 filter: wb_we=1, wb_reg=0, wb_data=32'hFFFF_FFFF → no tr_valid, tr_count stays 0.
- Full and overflow with DEPTH=16, tr_ready=0: 17 events with data 1..17 → first 16 retained in order 1..16; overflow=1; tr_count=16. Then 18th event with tr_ready=1 and FIFO full → accepted, overflow still 1, tr_count=17.
- Back-pressure: tr_ready toggling 1,0,1,0 during a 5-event burst → no entry lost or duplicated; tr_data held stable while stalled.
- End of program: 3 events buffered, then pc=32'h58 in the same cycle as a 4th event, then drain with tr_ready=1 → 4 entries out, a later event at reg 9 is ignored, done=1 exactly after the 4th pop.
- Asynchronous reset: assert reset=0 mid-clock with 5 entries held → all outputs 0 immediately. After release, a new event is captured normally and tr_count=1.
